// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : alu_pkg
// Description : Shared definitions for the 16-bit ALU execute-stage slice:
//               ALU control codes, exception codes, sequencer state encoding
//               and small decode helpers.
// Revision    : 1.0 - initial release
// ============================================================================
package alu_pkg;

    // ALU control codes
    localparam logic [3:0] c_ctrl_add   = 4'h1;
    localparam logic [3:0] c_ctrl_sub   = 4'h2;
    localparam logic [3:0] c_ctrl_mul   = 4'h4;
    localparam logic [3:0] c_ctrl_div   = 4'h8;
    localparam logic [3:0] c_ctrl_andi  = 4'hC;
    localparam logic [3:0] c_ctrl_ori   = 4'hE;
    localparam logic [3:0] c_ctrl_addnf = 4'hF;

    // Exception codes reported on exc_code
    localparam logic [1:0] c_exc_none    = 2'd0;
    localparam logic [1:0] c_exc_ovf     = 2'd1;
    localparam logic [1:0] c_exc_div0    = 2'd2;
    localparam logic [1:0] c_exc_illegal = 2'd3;

    // Execute-stage sequencer states
    typedef enum logic [2:0] {
        c_st_idle  = 3'd0,
        c_st_exec  = 3'd1,
        c_st_wb_rd = 3'd2,
        c_st_wb_r0 = 3'd3,
        c_st_exc   = 3'd4
    } exec_state_t;

    // Multi-cycle operations that also produce an r0 result
    function automatic logic is_muldiv(input logic [3:0] ctrl);
        return (ctrl == c_ctrl_mul) || (ctrl == c_ctrl_div);
    endfunction

    // Control codes the ALU understands
    function automatic logic is_legal(input logic [3:0] ctrl);
        logic w_legal;
        case (ctrl)
            c_ctrl_add, c_ctrl_sub, c_ctrl_mul, c_ctrl_div,
            c_ctrl_andi, c_ctrl_ori, c_ctrl_addnf: w_legal = 1'b1;
            default:                               w_legal = 1'b0;
        endcase
        return w_legal;
    endfunction

    // Logic ops cannot overflow, so the ALU flag is meaningless for them
    function automatic logic ovf_checked(input logic [3:0] ctrl);
        return (ctrl != c_ctrl_andi) && (ctrl != c_ctrl_ori);
    endfunction

endpackage
`default_nettype wire

// File: rtl/alu_exec_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : alu_exec_ctrl
// Description : Execute-stage sequencer for the 16-bit signed ALU. Accepts one
//               operation over valid/ready, drives the ALU for the required
//               latency, then writes the result (and r0 for mul/div) through
//               the single register-file port or raises an exception.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_exec_ctrl
    import alu_pkg::*;
#(
    parameter int unsigned MULDIV_LAT = 3,
    parameter logic [3:0]  R0_ADDR    = 4'd0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        op_valid,
    output logic        op_ready,
    input  logic [3:0]  op_ctrl,
    input  logic [15:0] op_a,
    input  logic [15:0] op_b,
    input  logic [3:0]  op_rd,
    output logic [15:0] alu_in1,
    output logic [15:0] alu_in2,
    output logic [3:0]  alu_ctrl,
    input  logic [15:0] alu_out,
    input  logic [15:0] alu_r0,
    input  logic        alu_ovf,
    output logic        wb_en,
    output logic [3:0]  wb_addr,
    output logic [15:0] wb_data,
    output logic        exc_valid,
    output logic [1:0]  exc_code,
    input  logic        exc_ack,
    output logic        busy
);

    localparam logic [3:0] c_muldiv_lat = 4'(MULDIV_LAT);

    exec_state_t r_state;
    logic [3:0]  r_ctrl;
    logic [3:0]  r_rd;
    logic [3:0]  r_cnt;
    logic [15:0] r_r0;

    // Sequencer: every output is a register so the ALU and register file see
    // glitch-free controls that change only on state transitions.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state   <= c_st_idle;
            r_ctrl    <= '0;
            r_rd      <= '0;
            r_cnt     <= '0;
            r_r0      <= '0;
            op_ready  <= 1'b1;
            busy      <= 1'b0;
            alu_in1   <= '0;
            alu_in2   <= '0;
            alu_ctrl  <= '0;
            wb_en     <= 1'b0;
            wb_addr   <= '0;
            wb_data   <= '0;
            exc_valid <= 1'b0;
            exc_code  <= c_exc_none;
        end else begin
            case (r_state)
                c_st_idle: begin
                    if (op_valid && op_ready) begin
                        r_ctrl   <= op_ctrl;
                        r_rd     <= op_rd;
                        op_ready <= 1'b0;
                        busy     <= 1'b1;
                        if (!is_legal(op_ctrl)) begin
                            r_state   <= c_st_exc;
                            exc_valid <= 1'b1;
                            exc_code  <= c_exc_illegal;
                        end else if ((op_ctrl == c_ctrl_div) && (op_b == 16'd0)) begin
                            // Divide-by-zero is caught before the ALU is ever driven
                            r_state   <= c_st_exc;
                            exc_valid <= 1'b1;
                            exc_code  <= c_exc_div0;
                        end else begin
                            r_state  <= c_st_exec;
                            alu_in1  <= op_a;
                            alu_in2  <= op_b;
                            alu_ctrl <= op_ctrl;
                            r_cnt    <= is_muldiv(op_ctrl) ? c_muldiv_lat : 4'd1;
                        end
                    end
                end

                c_st_exec: begin
                    if (r_cnt == 4'd1) begin
                        // Final ALU cycle: capture results and release the ALU
                        alu_in1  <= '0;
                        alu_in2  <= '0;
                        alu_ctrl <= '0;
                        r_cnt    <= '0;
                        r_r0     <= alu_r0;
                        if (alu_ovf && ovf_checked(r_ctrl)) begin
                            r_state   <= c_st_exc;
                            exc_valid <= 1'b1;
                            exc_code  <= c_exc_ovf;
                        end else begin
                            r_state <= c_st_wb_rd;
                            wb_en   <= 1'b1;
                            wb_addr <= r_rd;
                            wb_data <= alu_out;
                        end
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end

                c_st_wb_rd: begin
                    if (is_muldiv(r_ctrl)) begin
                        // Second write follows the first, so r0 wins when rd aliases R0
                        r_state <= c_st_wb_r0;
                        wb_addr <= R0_ADDR;
                        wb_data <= r_r0;
                    end else begin
                        r_state  <= c_st_idle;
                        wb_en    <= 1'b0;
                        wb_addr  <= '0;
                        wb_data  <= '0;
                        op_ready <= 1'b1;
                        busy     <= 1'b0;
                    end
                end

                c_st_wb_r0: begin
                    r_state  <= c_st_idle;
                    wb_en    <= 1'b0;
                    wb_addr  <= '0;
                    wb_data  <= '0;
                    op_ready <= 1'b1;
                    busy     <= 1'b0;
                end

                c_st_exc: begin
                    if (exc_ack) begin
                        r_state   <= c_st_idle;
                        exc_valid <= 1'b0;
                        exc_code  <= c_exc_none;
                        op_ready  <= 1'b1;
                        busy      <= 1'b0;
                    end
                end

                default: begin
                    r_state   <= c_st_idle;
                    alu_in1   <= '0;
                    alu_in2   <= '0;
                    alu_ctrl  <= '0;
                    wb_en     <= 1'b0;
                    wb_addr   <= '0;
                    wb_data   <= '0;
                    exc_valid <= 1'b0;
                    exc_code  <= c_exc_none;
                    op_ready  <= 1'b1;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_alu_exec_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_exec_ctrl
// Description : Scoreboard bench for alu_exec_ctrl with a stand-in ALU,
//               directed cases and randomized operations.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_exec_ctrl;

    localparam int unsigned LAT = 3;
    localparam logic [3:0]  R0  = 4'd0;

    localparam int c_ev_wb  = 0;
    localparam int c_ev_exc = 1;
    localparam int c_ev_rdy = 2;

    logic        clk;
    logic        reset;
    logic        op_valid;
    logic        op_ready;
    logic [3:0]  op_ctrl;
    logic [15:0] op_a;
    logic [15:0] op_b;
    logic [3:0]  op_rd;
    logic [15:0] alu_in1;
    logic [15:0] alu_in2;
    logic [3:0]  alu_ctrl;
    logic [15:0] alu_out;
    logic [15:0] alu_r0;
    logic        alu_ovf;
    logic        wb_en;
    logic [3:0]  wb_addr;
    logic [15:0] wb_data;
    logic        exc_valid;
    logic [1:0]  exc_code;
    logic        exc_ack;
    logic        busy;

    alu_exec_ctrl #(
        .MULDIV_LAT (LAT),
        .R0_ADDR    (R0)
    ) u_dut (
        .clk       (clk),
        .reset     (reset),
        .op_valid  (op_valid),
        .op_ready  (op_ready),
        .op_ctrl   (op_ctrl),
        .op_a      (op_a),
        .op_b      (op_b),
        .op_rd     (op_rd),
        .alu_in1   (alu_in1),
        .alu_in2   (alu_in2),
        .alu_ctrl  (alu_ctrl),
        .alu_out   (alu_out),
        .alu_r0    (alu_r0),
        .alu_ovf   (alu_ovf),
        .wb_en     (wb_en),
        .wb_addr   (wb_addr),
        .wb_data   (wb_data),
        .exc_valid (exc_valid),
        .exc_code  (exc_code),
        .exc_ack   (exc_ack),
        .busy      (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Stand-in combinational ALU; inj_ovf forces the overflow flag
    logic signed [31:0] s_a, s_b, s_res, s_rem;
    logic               s_ovf;
    logic               inj_ovf;
    assign s_a = {{16{alu_in1[15]}}, alu_in1};
    assign s_b = {{16{alu_in2[15]}}, alu_in2};
    always_comb begin
        s_res = '0;
        s_rem = '0;
        s_ovf = 1'b0;
        case (alu_ctrl)
            4'h1, 4'hF: begin s_res = s_a + s_b; s_ovf = (s_res > 32767) || (s_res < -32768); end
            4'h2:       begin s_res = s_a - s_b; s_ovf = (s_res > 32767) || (s_res < -32768); end
            4'h4:       s_res = s_a * s_b;
            4'h8:       if (s_b != 0) begin s_res = s_a / s_b; s_rem = s_a % s_b; end
            4'hC:       s_res = s_a & s_b;
            4'hE:       s_res = s_a | s_b;
            default:    ;
        endcase
    end
    assign alu_out = s_res[15:0];
    assign alu_r0  = (alu_ctrl == 4'h4) ? s_res[31:16] : s_rem[15:0];
    assign alu_ovf = s_ovf | inj_ovf;

    // Scoreboard
    typedef struct {
        int          kind;
        logic [3:0]  addr;
        logic [15:0] data;
        logic [1:0]  code;
        int          cyc;
    } ev_t;

    ev_t         sbq[$];
    logic [35:0] alu_tl[int];   // expected {ctrl,in1,in2} per cycle
    int          cyc = 0;
    int          n_checks = 0;
    int          n_pass = 0;
    bit          mon_en = 1'b0;
    bit          prev_v = 1'b0;
    bit          prev_ack = 1'b0;
    logic [1:0]  cur_code = 2'd0;

    function automatic void chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    endfunction

    function automatic void push_ev(input int kind, input logic [3:0] addr, input logic [15:0] data,
                                    input logic [1:0] code, input int at);
        ev_t e;
        e.kind = kind; e.addr = addr; e.data = data; e.code = code; e.cyc = at;
        sbq.push_back(e);
    endfunction

    // Reference model: cycle n after the accept edge is observed at cyc == acc + n
    function automatic void predict(input logic [3:0] c, input logic [15:0] a, input logic [15:0] b,
                                    input logic [3:0] rd, input bit inj, input int acc);
        int ia, ib, r, m, lat;
        bit ovf, md;
        logic [15:0] res, res0;
        ia = int'($signed(a));
        ib = int'($signed(b));
        if (!(c inside {4'h1, 4'h2, 4'h4, 4'h8, 4'hC, 4'hE, 4'hF})) begin
            push_ev(c_ev_exc, 4'd0, 16'd0, 2'd3, acc + 1);
        end else if (c == 4'h8 && ib == 0) begin
            push_ev(c_ev_exc, 4'd0, 16'd0, 2'd2, acc + 1);
        end else begin
            md  = (c == 4'h4) || (c == 4'h8);
            lat = md ? int'(LAT) : 1;
            for (int k = 1; k <= lat; k++) alu_tl[acc + k] = {c, a, b};
            ovf = inj; res = '0; res0 = '0; r = 0; m = 0;
            case (c)
                4'h1, 4'hF: begin r = ia + ib; ovf = ovf || r > 32767 || r < -32768; res = r[15:0]; end
                4'h2:       begin r = ia - ib; ovf = ovf || r > 32767 || r < -32768; res = r[15:0]; end
                4'h4:       begin r = ia * ib; res = r[15:0]; res0 = r[31:16]; end
                4'h8:       begin r = ia / ib; m = ia % ib; res = r[15:0]; res0 = m[15:0]; end
                4'hC:       res = a & b;
                default:    res = a | b;
            endcase
            if (ovf && c != 4'hC && c != 4'hE) begin
                push_ev(c_ev_exc, 4'd0, 16'd0, 2'd1, acc + lat + 1);
            end else begin
                push_ev(c_ev_wb, rd, res, 2'd0, acc + lat + 1);
                if (md) begin
                    push_ev(c_ev_wb, R0, res0, 2'd0, acc + lat + 2);
                    push_ev(c_ev_rdy, 4'd0, 16'd0, 2'd0, acc + lat + 3);
                end else begin
                    push_ev(c_ev_rdy, 4'd0, 16'd0, 2'd0, acc + lat + 2);
                end
            end
        end
    endfunction

    initial forever @(posedge clk) cyc++;

    // Monitor: compares DUT outputs against the scoreboard every cycle
    initial begin
        ev_t         e;
        logic [35:0] exp_alu;
        forever begin
            @(negedge clk);
            if (mon_en) begin
                while (sbq.size() > 0 && sbq[0].cyc < cyc) begin
                    e = sbq.pop_front();
                    chk($sformatf("missing_event_k%0d", e.kind), 64'(cyc), 64'(e.cyc));
                end
                exp_alu = alu_tl.exists(cyc) ? alu_tl[cyc] : 36'd0;
                if (alu_tl.exists(cyc)) alu_tl.delete(cyc);
                chk("alu_drive", {alu_ctrl, alu_in1, alu_in2}, exp_alu);
                chk("ready_busy_excl", busy ^ op_ready, 1);
                if (sbq.size() > 0 && sbq[0].kind == c_ev_rdy && sbq[0].cyc == cyc) begin
                    void'(sbq.pop_front());
                    chk("ready_after_wb", op_ready, 1);
                end
                if (wb_en) begin
                    if (sbq.size() > 0 && sbq[0].kind == c_ev_wb && sbq[0].cyc == cyc) begin
                        e = sbq.pop_front();
                        chk("wb_addr", wb_addr, e.addr);
                        chk("wb_data", wb_data, e.data);
                    end else begin
                        chk("unexpected_wb", wb_en, 0);
                    end
                end else begin
                    chk("wb_idle_zero", {wb_addr, wb_data}, 0);
                end
                if (exc_valid && !(prev_v && !prev_ack)) begin
                    if (sbq.size() > 0 && sbq[0].kind == c_ev_exc && sbq[0].cyc == cyc) begin
                        e = sbq.pop_front();
                        cur_code = e.code;
                        chk("exc_code", exc_code, e.code);
                    end else begin
                        chk("unexpected_exc", exc_valid, 0);
                    end
                end else if (prev_v && !prev_ack) begin
                    chk("exc_hold", {exc_valid, exc_code}, {1'b1, cur_code});
                end else if (prev_v && prev_ack) begin
                    chk("ack_to_idle", {exc_valid, exc_code, op_ready}, 4'b0001);
                end else begin
                    chk("exc_idle", {exc_valid, exc_code}, 0);
                end
                prev_v   = exc_valid;
                prev_ack = exc_ack;
            end
        end
    end

    // Exception acknowledger: holds each exception a few cycles, and also
    // pulses exc_ack at random while no exception is pending
    initial begin
        int hold = 0;
        int target = 5;
        exc_ack = 1'b0;
        forever begin
            @(posedge clk);
            #2;
            if (exc_valid) begin
                hold++;
                if (hold >= target) begin
                    exc_ack = 1'b1;
                    hold    = 0;
                    target  = $urandom_range(1, 6);
                end else begin
                    exc_ack = 1'b0;
                end
            end else begin
                hold    = 0;
                exc_ack = ($urandom_range(0, 7) == 0);
            end
        end
    end

    // Offers one op (entered and left at a negedge); valid may stay high
    task automatic issue(input logic [3:0] c, input logic [15:0] a, input logic [15:0] b,
                         input logic [3:0] rd, input bit inj, input bit gap);
        int waits = 0;
        op_valid = 1'b1; op_ctrl = c; op_a = a; op_b = b; op_rd = rd;
        while (!op_ready && waits <= 100) begin
            @(negedge clk);
            waits++;
        end
        if (!op_ready) begin
            chk("accept_timeout", op_ready, 1);
        end else begin
            inj_ovf = inj;
            predict(c, a, b, rd, inj, cyc);
        end
        @(negedge clk);
        if (gap) begin
            op_valid = 1'b0;
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end
    endtask

    task automatic wait_idle();
        int n = 0;
        op_valid = 1'b0;
        while (!(sbq.size() == 0 && op_ready && !exc_valid) && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("drain_idle", {sbq.size() == 0, op_ready, exc_valid}, 3'b110);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    logic [3:0] codes [7] = '{4'h1, 4'h2, 4'h4, 4'h8, 4'hC, 4'hE, 4'hF};

    initial begin
        logic [3:0]  c;
        logic [15:0] a, b;
        int          acc;
        reset = 1'b0; op_valid = 1'b0; op_ctrl = '0; op_a = '0; op_b = '0; op_rd = '0; inj_ovf = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_outputs", {op_ready, busy, alu_in1, alu_in2, alu_ctrl, wb_en, wb_addr, wb_data,
                              exc_valid, exc_code}, {1'b1, 61'd0});
        reset  = 1'b1;
        mon_en = 1'b1;
        @(negedge clk);

        // Directed cases
        issue(4'h1, 16'd5,      16'd7,      4'd3, 1'b0, 1'b1);
        issue(4'h4, 16'd300,    16'd300,    4'd5, 1'b0, 1'b0);
        issue(4'h8, 16'd17,     16'd5,      4'd2, 1'b0, 1'b0);
        issue(4'h8, 16'd17,     16'd0,      4'd6, 1'b0, 1'b1);
        issue(4'h1, 16'h7FFF,   16'd1,      4'd4, 1'b0, 1'b1);
        issue(4'hE, 16'h00F0,   16'h0F0F,   4'd7, 1'b1, 1'b1);
        issue(4'h3, 16'd1,      16'd2,      4'd8, 1'b0, 1'b0);
        issue(4'h4, 16'hFFFF,   16'd2,      4'd0, 1'b0, 1'b0);
        issue(4'hC, 16'hF0F0,   16'h3C3C,   4'd9, 1'b1, 1'b0);
        issue(4'h8, 16'h8000,   16'hFFFF,   4'd1, 1'b0, 1'b1);
        issue(4'h2, 16'h8000,   16'd1,      4'd2, 1'b0, 1'b1);

        // Randomized operations
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 9) == 0) c = 4'($urandom);
            else                           c = codes[$urandom_range(0, 6)];
            a = ($urandom_range(0, 3) == 0) ? 16'($urandom_range(0, 20)) : 16'($urandom);
            b = ($urandom_range(0, 3) == 0) ? 16'($urandom_range(0, 20)) : 16'($urandom);
            issue(c, a, b, 4'($urandom), ($urandom_range(0, 5) == 0), ($urandom_range(0, 1) == 1));
        end
        wait_idle();

        // Reset during a MUL: nothing of it may be written back
        op_valid = 1'b1; op_ctrl = 4'h4; op_a = 16'd300; op_b = 16'd300; op_rd = 4'd5; inj_ovf = 1'b0;
        acc = cyc;
        alu_tl[acc + 1] = {4'h4, 16'd300, 16'd300};
        alu_tl[acc + 2] = {4'h4, 16'd300, 16'd300};
        @(negedge clk);
        op_valid = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("reset_midop", {op_ready, busy, alu_in1, alu_in2, alu_ctrl, wb_en, wb_addr, wb_data,
                            exc_valid, exc_code}, {1'b1, 61'd0});
        reset = 1'b1;
        repeat (8) @(negedge clk);

        issue(4'h1, 16'd5, 16'd7, 4'd3, 1'b0, 1'b1);
        wait_idle();
        chk("queue_empty", sbq.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/alu_exec_ctrl.md
Name: alu_exec_ctrl

Overview:
Execute-stage sequencer for the 16-bit signed ALU. It accepts one operation at a time over a valid/ready handshake and drives the ALU operand and control inputs. It waits the required latency (1 cycle for logic/add/sub, MULDIV_LAT cycles for mul/div), then writes back the result, plus R0 for mul/div, through the single register-file write port. It raises an exception instead of writing back on overflow, divide-by-zero or an illegal control code.

Parameters:
MULDIV_LAT, 3, EXEC cycles for ctrl 4'h4/4'h8; legal range 1..15.
R0_ADDR, 4'd0, register-file address receiving the ALU r0 output (mul high half / div remainder).

Ports:
clk  in  1  rising-edge clock
reset  in  1  reset, synchronous, active-low
op_valid  in  1  operation offered
op_ready  out  1  controller can accept; high only in IDLE
op_ctrl  in  4  ALU code: 1 add, 2 sub, 4 mul, 8 div, C andi, E ori, F add-nofunc
op_a  in  16  signed operand 1
op_b  in  16  signed operand 2
op_rd  in  4  destination register
alu_in1  out  16  to ALU in1
alu_in2  out  16  to ALU in2
alu_ctrl  out  4  to ALU ctrl; 0 when not in EXEC
alu_out  in  16  ALU result
alu_r0  in  16  ALU r0 result
alu_ovf  in  1  ALU overflow flag
wb_en  out  1  register-file write strobe
wb_addr  out  4  write address
wb_data  out  16  write data
exc_valid  out  1  exception pending
exc_code  out  2  1 overflow, 2 divide-by-zero, 3 illegal ctrl
exc_ack  in  1  clears exception
busy  out  1  high in any state other than IDLE

Behaviour:
- States: IDLE, EXEC, WB_RD, WB_R0, EXC.
- Reset:
  - When reset is low at a clock edge, the controller enters IDLE regardless of the current state.
  - All outputs are 0 except op_ready, which is 1.
  - Any in-flight operation is discarded and no write-back occurs.
- IDLE:
  - op_valid & op_ready accepts the op; op_ctrl/op_a/op_b/op_rd are registered.
  - If op_ctrl is not in {1,2,4,8,C,E,F}, go to EXC with code 3.
  - Else if op_ctrl==8 and op_b==0, go to EXC with code 2; the ALU is never driven.
  - Otherwise go to EXEC and load the cycle counter: 1 for single-cycle ops, MULDIV_LAT for mul/div.
- EXEC:
  - alu_in1/alu_in2/alu_ctrl are driven from the registered values and held stable for the whole state.
  - The counter decrements each cycle.
  - On the cycle the counter equals 1, alu_out, alu_r0 and alu_ovf are captured into result registers.
  - If alu_ovf=1 and ctrl is in {1,2,4,8,F}, go to EXC with code 1. alu_ovf is ignored for C/E.
  - Otherwise go to WB_RD.
- WB_RD: wb_en=1, wb_addr=rd, wb_data=captured out, for one cycle. Then go to WB_R0 for mul/div, else IDLE.
- WB_R0: wb_en=1, wb_addr=R0_ADDR, wb_data=captured r0, for one cycle, then IDLE. If rd==R0_ADDR, both writes still occur and the r0 value (second write) wins.
- EXC:
  - exc_valid=1 and exc_code is stable; no write-back.
  - Stays until exc_ack=1, then IDLE.
  - exc_ack outside EXC is ignored.
- Latency (op accepted at edge 0):
  - Single-cycle op: EXEC is cycle 1, wb_en is high in cycle 2.
  - Mul/div: EXEC is cycles 1..MULDIV_LAT, WB_RD is cycle MULDIV_LAT+1, WB_R0 is cycle MULDIV_LAT+2.
  - The next op can be accepted in the cycle after the last write.
- Throughput: op_ready=0 while busy; op_valid held during busy is accepted only once back in IDLE.
- Outside WB states, wb_addr and wb_data are 0. Outside EXEC, alu_in1 and alu_in2 are 0.

Decomposition:
- Shared package alu_pkg:
  - ALU ctrl code constants (ADD=1, SUB=2, MUL=4, DIV=8, ANDI=C, ORI=E, ADDNF=F)
  - exception code constants
  - controller state encoding
  - is_muldiv and is_legal helper functions
- No sub-module; the latency counter is a 4-bit down-counter inline.

Test Plan:
- ADD op_a=5, op_b=7, rd=3 accepted at cycle 0 -> wb_en=1 in cycle 2 only, wb_addr=3, wb_data=12; op_ready=1 in cycle 3.
- MUL 300*300, rd=5, MULDIV_LAT=3 -> cycle 4: wb addr 5 data 16'h5F90; cycle 5: wb addr 0 data 16'h0001; alu_ctrl=4 in cycles 1-3 only.
- DIV 17/5, rd=2 -> wb addr 2 data 3, then addr 0 data 2; DIV 17/0 -> exc_valid=1 code 2 from cycle 1, no wb_en, alu_ctrl stays 0; exc_ack -> IDLE.
- ADD 16'h7FFF+1 with alu_ovf=1 -> exc code 1, no wb_en, exc_valid held 5 cycles until exc_ack; ORI with alu_ovf=1 -> normal write-back.
- op_ctrl=4'h3 -> exc code 3, ALU untouched; op_valid held high during a busy MUL -> accepted only after WB_R0.
- MUL accepted, reset low in cycle 2 -> IDLE next edge, all outputs 0, op_ready=1, no wb_en ever asserted for that op.
